// File: rtl/xbar2_pkg.sv
// Shared constants and types for the two-port crossbar router.
package xbar2_pkg;
   localparam int NUM_PORTS = 2;
   localparam int STATS_W   = 16;

   typedef logic src_idx_t;

   localparam src_idx_t PTR_RST = 1'b0;
endpackage

// File: rtl/xbar2_out_port.sv
// One router output: request decode, round-robin arbiter, one-entry holding register.
// Optional load counter when XBAR2_ROUTER_STATS_EN is defined.
module xbar2_out_port
   import xbar2_pkg::*;
#(
   parameter int   Data_Width   = 8,
   parameter int   Select_Width = 2,
   parameter logic PORT_IDX     = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    v0,
   input  logic                    v1,
   input  logic                    d0,
   input  logic                    d1,
   input  logic [Data_Width-1:0]   x0,
   input  logic [Data_Width-1:0]   x1,
   input  logic                    yr,
   output logic                    gnt0,
   output logic                    gnt1,
   output logic [Data_Width-1:0]   y,
   output logic                    yv,
   output logic [Select_Width-1:0] s
`ifdef XBAR2_ROUTER_STATS_EN
   ,
   output logic [STATS_W-1:0]      cnt
`endif
);

   logic                  req0;
   logic                  req1;
   logic                  free;
   logic                  load;
   src_idx_t              win;

   logic [Data_Width-1:0] y_d, y_q;
   logic                  yv_d, yv_q;
   src_idx_t              src_d, src_q;
   src_idx_t              ptr_d, ptr_q;

   always_comb begin
      req0 = v0 & (d0 == PORT_IDX);
      req1 = v1 & (d1 == PORT_IDX);
      free = !yv_q | yr;
      // Pointer only matters under contention; a lone requester always wins.
      win  = (req0 & req1) ? ptr_q : req1;
      load = (req0 | req1) & free & rst_n;
      gnt0 = load & !win;
      gnt1 = load & win;

      y_d   = y_q;
      yv_d  = yv_q & !yr;
      src_d = src_q;
      ptr_d = ptr_q;
      if (load) begin
         y_d   = win ? x1 : x0;
         yv_d  = 1'b1;
         src_d = win;
         ptr_d = !win;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q   <= '0;
         yv_q  <= 1'b0;
         src_q <= 1'b0;
         ptr_q <= PTR_RST;
      end else begin
         y_q   <= y_d;
         yv_q  <= yv_d;
         src_q <= src_d;
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      s    = '0;
      s[0] = src_q;
   end

   assign y  = y_q;
   assign yv = yv_q;

`ifdef XBAR2_ROUTER_STATS_EN
   logic [STATS_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q + STATS_W'(load);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
`endif

endmodule

// File: rtl/xbar2_router.sv
// Two-in / two-out push router; one xbar2_out_port per output, grants ORed into input readies.
// Define XBAR2_ROUTER_STATS_EN to add per-output load counters CNT0/CNT1.
module xbar2_router
   import xbar2_pkg::*;
#(
   parameter int Data_Width   = 8,
   parameter int Select_Width = 2
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [Data_Width-1:0]   X0,
   input  logic [Data_Width-1:0]   X1,
   input  logic                    V0,
   input  logic                    V1,
   input  logic                    D0,
   input  logic                    D1,
   output logic                    R0,
   output logic                    R1,
   output logic [Data_Width-1:0]   Y0,
   output logic [Data_Width-1:0]   Y1,
   output logic                    YV0,
   output logic                    YV1,
   input  logic                    YR0,
   input  logic                    YR1,
   output logic [Select_Width-1:0] S0,
   output logic [Select_Width-1:0] S1
`ifdef XBAR2_ROUTER_STATS_EN
   ,
   output logic [STATS_W-1:0]      CNT0,
   output logic [STATS_W-1:0]      CNT1
`endif
);

   // gnt_oJ[i]: output J has granted input i this cycle.
   logic [NUM_PORTS-1:0] gnt_o0;
   logic [NUM_PORTS-1:0] gnt_o1;

   xbar2_out_port #(
      .Data_Width   (Data_Width),
      .Select_Width (Select_Width),
      .PORT_IDX     (1'b0)
   ) u_out0 (
      .clk   (CLK),
      .rst_n (RST_N),
      .v0    (V0),
      .v1    (V1),
      .d0    (D0),
      .d1    (D1),
      .x0    (X0),
      .x1    (X1),
      .yr    (YR0),
      .gnt0  (gnt_o0[0]),
      .gnt1  (gnt_o0[1]),
      .y     (Y0),
      .yv    (YV0),
      .s     (S0)
`ifdef XBAR2_ROUTER_STATS_EN
      ,
      .cnt   (CNT0)
`endif
   );

   xbar2_out_port #(
      .Data_Width   (Data_Width),
      .Select_Width (Select_Width),
      .PORT_IDX     (1'b1)
   ) u_out1 (
      .clk   (CLK),
      .rst_n (RST_N),
      .v0    (V0),
      .v1    (V1),
      .d0    (D0),
      .d1    (D1),
      .x0    (X0),
      .x1    (X1),
      .yr    (YR1),
      .gnt0  (gnt_o1[0]),
      .gnt1  (gnt_o1[1]),
      .y     (Y1),
      .yv    (YV1),
      .s     (S1)
`ifdef XBAR2_ROUTER_STATS_EN
      ,
      .cnt   (CNT1)
`endif
   );

   assign R0 = gnt_o0[0] | gnt_o1[0];
   assign R1 = gnt_o0[1] | gnt_o1[1];

endmodule
